// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans an active-low NumRows x NumCols key matrix one row at a time,
// synchronizes the column lines, and debounces whole-matrix snapshots.
// keys_o only takes a new value after DebounceScans consecutive identical
// full scans.
//
// Ports:
//   clk_i        in   1                system clock
//   rst_ni       in   1                asynchronous, active-low reset
//   cols_i       in   NumCols          raw column lines, pulled up, low = pressed
//   rows_o       out  NumRows          active-low one-hot row drive, '1 = idle
//   keys_o       out  NumRows*NumCols  debounced key state, bit r*NumCols+c
//   changed_o    out  1                pulse in the cycle keys_o takes a new value
//   scan_done_o  out  1                pulse in the compare cycle of every scan
//
// Build option:
//   GHOST_REJECT_EN  when defined, a scan containing a ghosting rectangle
//                    (two rows sharing two or more pressed columns) is
//                    treated as unstable and never reaches keys_o.
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int NumRows       = 4,
  parameter int NumCols       = 4,
  parameter int SettleCycles  = 16,
  parameter int DebounceScans = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumCols-1:0]         cols_i,
  output logic [NumRows-1:0]         rows_o,
  output logic [NumRows*NumCols-1:0] keys_o,
  output logic                       changed_o,
  output logic                       scan_done_o
);

  localparam int NumKeys = NumRows * NumCols;
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SetW    = $clog2(SettleCycles);
  localparam int StbW    = (DebounceScans > 1) ? $clog2(DebounceScans) : 1;

  localparam logic [RowW-1:0] LastRow    = RowW'(NumRows - 1);
  localparam logic [SetW-1:0] LastSettle = SetW'(SettleCycles - 1);
  localparam logic [StbW-1:0] StableMax  = StbW'(DebounceScans - 1);

  // The two synchronizer flops eat two of the settle cycles, so fewer than
  // three would leave no real settling time before the sample.
  generate
    if (SettleCycles < 3) begin : g_settle_check
      $error("keypad_scanner: SettleCycles must be at least 3");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DRIVE   = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_COMPARE = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [NumCols-1:0]   r_sync1, r_sync2;
  logic [NumCols-1:0]   w_pressed;
  logic [SetW-1:0]      r_settle, w_settle_next;
  logic [RowW-1:0]      r_row, w_row_next;
  logic [NumKeys-1:0]   r_scan, w_scan_next;
  logic [NumKeys-1:0]   r_prev, w_prev_next;
  logic [StbW-1:0]      r_stable, w_stable_next;
  logic [NumKeys-1:0]   r_keys, w_keys_next;
  logic                 r_changed, w_changed_next;
  logic [NumRows-1:0]   r_rows, w_rows_next;
  logic                 w_ghost;

  // Columns are pulled up, so a low line means the key is pressed.
  assign w_pressed = ~r_sync2;

`ifdef GHOST_REJECT_EN
  // One flag per unordered row pair: set when the pair shares at least two
  // pressed columns. x & (x-1) is non-zero exactly when x has two or more bits.
  logic [NumRows*NumRows-1:0] w_pair;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NumRows; gi++) begin : g_row_a
      for (gj = 0; gj < NumRows; gj++) begin : g_row_b
        if (gj > gi) begin : g_pair
          logic [NumCols-1:0] w_common;
          assign w_common = r_scan[gi*NumCols +: NumCols] & r_scan[gj*NumCols +: NumCols];
          assign w_pair[gi*NumRows+gj] = |(w_common & (w_common - NumCols'(1)));
        end else begin : g_none
          assign w_pair[gi*NumRows+gj] = 1'b0;
        end
      end
    end
  endgenerate

  assign w_ghost = |w_pair;
`else
  assign w_ghost = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_settle_next  = r_settle;
    w_row_next     = r_row;
    w_scan_next    = r_scan;
    w_prev_next    = r_prev;
    w_stable_next  = r_stable;
    w_keys_next    = r_keys;
    w_changed_next = 1'b0;

    case (r_state)
      ST_DRIVE: begin
        if (r_settle == LastSettle) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_settle_next = r_settle + SetW'(1);
        end
      end

      ST_SAMPLE: begin
        w_scan_next[r_row*NumCols +: NumCols] = w_pressed;
        if (r_row == LastRow) begin
          w_state_next = ST_COMPARE;
        end else begin
          w_row_next    = r_row + RowW'(1);
          w_settle_next = '0;
          w_state_next  = ST_DRIVE;
        end
      end

      ST_COMPARE: begin
        if (w_ghost) begin
          w_stable_next = '0;
        end else if (r_scan != r_prev) begin
          w_stable_next = '0;
          w_prev_next   = r_scan;
        end else if (r_stable != StableMax) begin
          w_stable_next = r_stable + StbW'(1);
        end
        // In the non-ghost case the updated previous scan equals r_scan, which
        // also lets DebounceScans=1 publish on the very first differing scan.
        if (!w_ghost && (w_stable_next == StableMax) && (r_scan != r_keys)) begin
          w_keys_next    = r_scan;
          w_changed_next = 1'b1;
        end
        w_row_next    = '0;
        w_settle_next = '0;
        w_state_next  = ST_DRIVE;
      end

      default: begin
        w_state_next = ST_DRIVE;
      end
    endcase

    // Row drive is registered from the next state so it is glitch-free and
    // stays asserted through the sample cycle.
    if (w_state_next == ST_COMPARE) begin
      w_rows_next = '1;
    end else begin
      w_rows_next = ~(NumRows'(1) << w_row_next);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_DRIVE;
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_settle  <= '0;
      r_row     <= '0;
      r_scan    <= '0;
      r_prev    <= '0;
      r_stable  <= '0;
      r_keys    <= '0;
      r_changed <= 1'b0;
      r_rows    <= '1;
    end else begin
      r_state   <= w_state_next;
      r_sync1   <= cols_i;
      r_sync2   <= r_sync1;
      r_settle  <= w_settle_next;
      r_row     <= w_row_next;
      r_scan    <= w_scan_next;
      r_prev    <= w_prev_next;
      r_stable  <= w_stable_next;
      r_keys    <= w_keys_next;
      r_changed <= w_changed_next;
      r_rows    <= w_rows_next;
    end
  end

  assign rows_o      = r_rows;
  assign keys_o      = r_keys;
  assign changed_o   = r_changed;
  assign scan_done_o = (r_state == ST_COMPARE);

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int NR      = 4;
  localparam int NC      = 4;
  localparam int SETTLE  = 16;
  localparam int DS      = 4;
  localparam int ROWSPAN = SETTLE + 1;
  localparam int PERIOD  = NR * ROWSPAN + 1;
  localparam int WINDOW  = (DS + 1) * PERIOD + 3;

  logic        clk;
  logic        rst_ni;
  logic [3:0]  cols_i;
  logic [3:0]  rows_o;
  logic [15:0] keys_o;
  logic        changed_o;
  logic        scan_done_o;

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  logic [15:0] key_mat;

  int checks;
  int errors;

  // Reference model: cycle count since reset release, the per-row snapshot the
  // scanner is expected to have taken, and the debounce bookkeeping.
  int          n;
  logic [15:0] m_buf;
  logic [15:0] m_prev;
  logic [15:0] m_keys;
  int          m_run;
  bit          m_changed;

  keypad_scanner #(
    .NumRows(NR), .NumCols(NC), .SettleCycles(SETTLE), .DebounceScans(DS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .cols_i     (cols_i),
    .rows_o     (rows_o),
    .keys_o     (keys_o),
    .changed_o  (changed_o),
    .scan_done_o(scan_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cols_i = '1;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (key_mat[r*NC+c] && !rows_o[r]) cols_i[c] = 1'b0;
      end
    end
  end

  function automatic bit has_ghost(input logic [15:0] s);
    for (int a = 0; a < NR; a++) begin
      for (int b = a + 1; b < NR; b++) begin
        if ($countones(s[a*NC +: NC] & s[b*NC +: NC]) >= 2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] rows_exp(input int cnt);
    int p;
    logic [3:0] one;
    one = 4'b0001;
    p = cnt % PERIOD;
    if (cnt == 0 || p == PERIOD - 1) return 4'b1111;
    return ~(one << (p / ROWSPAN));
  endfunction

  task automatic model_reset();
    n         = 0;
    m_buf     = '0;
    m_prev    = '0;
    m_keys    = '0;
    m_run     = 1;
    m_changed = 1'b0;
  endtask

  // Advance one clock and update the model. Row r of each scan is sampled at
  // cycle offset (r+1)*ROWSPAN; through the two-flop synchronizer that sees
  // the matrix as it stood two cycles earlier. The result is published one
  // cycle after the compare slot, i.e. at every multiple of PERIOD.
  task automatic step();
    int q;
    bit ghost;
    @(posedge clk);
    #1;
    n++;
    q = (n + 2) % PERIOD;
    if (q != 0 && (q % ROWSPAN) == 0) begin
      m_buf[(q/ROWSPAN-1)*NC +: NC] = key_mat[(q/ROWSPAN-1)*NC +: NC];
    end
    m_changed = 1'b0;
    if (n >= PERIOD && (n % PERIOD) == 0) begin
      ghost = 1'b0;
`ifdef GHOST_REJECT_EN
      ghost = has_ghost(m_buf);
`endif
      // m_run = length of the current run of identical usable scans.
      if (ghost) m_run = 1;
      else if (m_buf != m_prev) begin
        m_run  = 1;
        m_prev = m_buf;
      end else if (m_run < DS) m_run = m_run + 1;
      if (!ghost && m_run == DS && m_buf != m_keys) begin
        m_keys    = m_buf;
        m_changed = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    key_mat = '0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rows_o !== 4'b1111) begin errors++; $display("FAIL reset_rows got %b want 1111", rows_o); end
    checks++; if (keys_o !== 16'h0000) begin errors++; $display("FAIL reset_keys got %h want 0000", keys_o); end
    checks++; if (changed_o !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed_o); end
    checks++; if (scan_done_o !== 1'b0) begin errors++; $display("FAIL reset_scan_done got %b want 0", scan_done_o); end
    rst_ni = 1'b1;
    model_reset();
    step();
    checks++; if (rows_o !== 4'b1110) begin errors++; $display("FAIL reset_first_row got %b want 1110", rows_o); end
    $display("test_reset: rows after release %b", rows_o);
  endtask

  task automatic test_single_key();
    int pulses;
    key_mat = 16'h0040;
    pulses = 0;
    for (int i = 0; i < WINDOW; i++) begin
      step();
      if (changed_o === 1'b1) pulses++;
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL single_press cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
    end
    checks++; if (keys_o !== 16'h0040) begin errors++; $display("FAIL single_press_final got %h want 0040", keys_o); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_press_pulses got %0d want 1", pulses); end
    $display("test_single_key: press keys %h pulses %0d", keys_o, pulses);
    key_mat = 16'h0000;
    pulses = 0;
    for (int i = 0; i < WINDOW; i++) begin
      step();
      if (changed_o === 1'b1) pulses++;
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL single_release cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
    end
    checks++; if (keys_o !== 16'h0000) begin errors++; $display("FAIL single_release_final got %h want 0000", keys_o); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_release_pulses got %0d want 1", pulses); end
    $display("test_single_key: release keys %h pulses %0d", keys_o, pulses);
  endtask

  task automatic test_bounce();
    int pulses;
    while ((n % PERIOD) != 0) begin
      step();
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL bounce_align cyc %0d keys %h want %h", n, keys_o, m_keys);
      end
    end
    pulses = 0;
    for (int t = 0; t < 1000; t++) begin
      key_mat[6] = (((t / 50) % 2) == 0);
      step();
      if (changed_o === 1'b1) pulses++;
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL bounce_toggle cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_no_change got %0d pulses want 0", pulses); end
    key_mat[6] = 1'b1;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL bounce_hold cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
    end
    checks++; if (keys_o !== 16'h0040) begin errors++; $display("FAIL bounce_final got %h want 0040", keys_o); end
    $display("test_bounce: toggle pulses %0d final keys %h", pulses, keys_o);
  endtask

  task automatic test_multi_key();
    int dones;
    key_mat = 16'h8001;
    dones = 0;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      if (scan_done_o === 1'b1) dones++;
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL multi_keys cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
      checks++;
      if (scan_done_o !== ((n % PERIOD) == PERIOD - 1)) begin
        errors++; $display("FAIL multi_scan_done cyc %0d got %b want %b", n, scan_done_o, ((n % PERIOD) == PERIOD - 1));
      end
      checks++;
      if (rows_o !== rows_exp(n)) begin
        errors++; $display("FAIL multi_rows cyc %0d got %b want %b", n, rows_o, rows_exp(n));
      end
    end
    checks++; if (keys_o !== 16'h8001) begin errors++; $display("FAIL multi_final got %h want 8001", keys_o); end
    checks++; if (dones != 6) begin errors++; $display("FAIL multi_done_count got %0d want 6", dones); end
    $display("test_multi_key: keys %h scan_done pulses %0d", keys_o, dones);
  endtask

  task automatic test_reset_mid_scan();
    key_mat = 16'h0040;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL midrst_pre cyc %0d keys %h want %h", n, keys_o, m_keys);
      end
    end
    checks++; if (keys_o !== 16'h0040) begin errors++; $display("FAIL midrst_pre_final got %h want 0040", keys_o); end
    while ((n % PERIOD) != 2 * ROWSPAN + 6) step();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (keys_o !== 16'h0000) begin errors++; $display("FAIL midrst_keys got %h want 0000", keys_o); end
    checks++; if (changed_o !== 1'b0) begin errors++; $display("FAIL midrst_changed got %b want 0", changed_o); end
    checks++; if (rows_o !== 4'b1111) begin errors++; $display("FAIL midrst_rows got %b want 1111", rows_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (keys_o !== 16'h0000 || changed_o !== 1'b0) begin
        errors++; $display("FAIL midrst_hold keys %h chg %b want 0000 0", keys_o, changed_o);
      end
    end
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed || rows_o !== rows_exp(n)) begin
        errors++; $display("FAIL midrst_rebuild cyc %0d keys %h chg %b rows %b want %h %b %b", n, keys_o, changed_o, rows_o, m_keys, m_changed, rows_exp(n));
      end
    end
    checks++; if (keys_o !== 16'h0040) begin errors++; $display("FAIL midrst_final got %h want 0040", keys_o); end
    $display("test_reset_mid_scan: rebuilt keys %h", keys_o);
  endtask

  task automatic test_ghost();
    int pulses;
    logic [15:0] want;
    int want_pulses;
    key_mat = 16'h0000;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL ghost_clear cyc %0d keys %h want %h", n, keys_o, m_keys);
      end
    end
    key_mat = 16'h0033;
    pulses = 0;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      step();
      if (changed_o === 1'b1) pulses++;
      checks++;
      if (keys_o !== m_keys || changed_o !== m_changed) begin
        errors++; $display("FAIL ghost_hold cyc %0d keys %h chg %b want %h %b", n, keys_o, changed_o, m_keys, m_changed);
      end
    end
`ifdef GHOST_REJECT_EN
    want = 16'h0000;
    want_pulses = 0;
`else
    want = 16'h0033;
    want_pulses = 1;
`endif
    checks++; if (keys_o !== want) begin errors++; $display("FAIL ghost_final got %h want %h", keys_o, want); end
    checks++; if (pulses != want_pulses) begin errors++; $display("FAIL ghost_pulses got %0d want %0d", pulses, want_pulses); end
    $display("test_ghost: keys %h pulses %0d", keys_o, pulses);
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    logic [15:0] base;
    logic [15:0] one16;
    int hold;
    one16 = 16'h0001;
    for (int it = 0; it < 14; it++) begin
      rnd = $urandom() & $urandom();
      base = rnd[15:0];
      hold = $urandom_range(1, 6) * PERIOD + $urandom_range(0, PERIOD - 1);
      for (int i = 0; i < hold; i++) begin
        key_mat = base;
        if ($urandom_range(0, 29) == 0) key_mat = base ^ (one16 << $urandom_range(0, 15));
        step();
        checks++;
        if (keys_o !== m_keys || changed_o !== m_changed) begin
          errors++; $display("FAIL random it %0d cyc %0d keys %h chg %b want %h %b", it, n, keys_o, changed_o, m_keys, m_changed);
        end
      end
      $display("test_random: pattern %h held %0d cycles keys %h", base, hold, keys_o);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    key_mat = '0;
    rst_ni  = 1'b0;
    model_reset();
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_reset_mid_scan();
    test_ghost();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
